ap_cam_array: RTL

//  Parametrised associative-processor CAM array: CELL_QUANT rows of WORD_SIZE bits.

---
 rtl/ap_cam_pkg.sv | 32 +++
 rtl/ap_cam_row.sv | 37 +++
 rtl/ap_cam_array.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ap_cam_pkg.sv
`default_nettype none
// ============================================================================
// ap_cam_pkg : opcodes, FSM states and width helper for the AP CAM array
// Revision   : 1.0
// ============================================================================
package ap_cam_pkg;

  typedef enum logic [1:0] {
    OP_WRITE        = 2'd0,
    OP_READ         = 2'd1,
    OP_COMPARE      = 2'd2,
    OP_WRITE_TAGGED = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Minimum 1 bit so a single-row array still has an address port.
  function automatic int clogb2(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 32; k++) begin
      if ((1 << w) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage : ap_cam_pkg
`default_nettype wire

// File: rtl/ap_cam_row.sv
`default_nettype none
// ============================================================================
// ap_cam_row : one CAM row with masked-compare match and masked-write port
// Revision   : 1.0
// ============================================================================
module ap_cam_row #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 we_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  logic [WORD_SIZE-1:0] wmask_i,
  input  logic [WORD_SIZE-1:0] key_i,
  input  logic [WORD_SIZE-1:0] cmask_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 match_o
);

  logic [WORD_SIZE-1:0] data_q;
  logic [WORD_SIZE-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) data_d = (data_q & ~wmask_i) | (wdata_i & wmask_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_o  = data_q;
  assign match_o = (((data_q ^ key_i) & cmask_i) == '0);

endmodule : ap_cam_row
`default_nettype wire

// File: rtl/ap_cam_array.sv
`default_nettype none
// ============================================================================
// ap_cam_array : associative-processor CAM array with valid/ready command port
//   Optional macro AP_CAM_MATCH_COUNT_EN adds the match_count popcount output.
// Revision     : 1.0
// ============================================================================
module ap_cam_array
  import ap_cam_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_W     = clogb2(CELL_QUANT)
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [WORD_SIZE-1:0]  dina,
  input  logic [WORD_SIZE-1:0]  key,
  input  logic [WORD_SIZE-1:0]  mask,
  output logic                  resp_valid,
  output logic [WORD_SIZE-1:0]  doutb,
  output logic [CELL_QUANT-1:0] tags,
  output logic                  match_any,
  output logic [ADDR_W-1:0]     match_addr
`ifdef AP_CAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_W:0]       match_count
`endif
);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_SIZE-1:0]  dina_q, key_q, mask_q;
  logic [CELL_QUANT-1:0] tags_q;
  logic [CELL_QUANT-1:0] row_we;
  logic [CELL_QUANT-1:0] row_match;
  logic [WORD_SIZE-1:0]  row_data [CELL_QUANT];
  logic [WORD_SIZE-1:0]  row_wmask;
  logic [WORD_SIZE-1:0]  doutb_q;
  logic                  resp_valid_q;
  logic                  match_any_q;
  logic [ADDR_W-1:0]     match_addr_q;
  logic [ADDR_W-1:0]     prio_addr;
  logic                  accept;
  logic                  addr_ok;

  assign accept  = cmd_valid && (state_q == ST_IDLE);
  // Widen by one bit so CELL_QUANT == 2**ADDR_W does not truncate to zero.
  assign addr_ok = ({1'b0, addr_q} < (ADDR_W + 1)'(CELL_QUANT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      op_q   <= OP_WRITE;
      addr_q <= '0;
      dina_q <= '0;
      key_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      op_q   <= op_e'(cmd_op);
      addr_q <= addr_in;
      dina_q <= dina;
      key_q  <= key;
      mask_q <= mask;
    end
  end

  // A plain WRITE replaces the whole row; WRITE_TAGGED touches only masked bits.
  assign row_wmask = (op_q == OP_WRITE_TAGGED) ? mask_q : '1;

  for (genvar i = 0; i < CELL_QUANT; i++) begin : g_row
    assign row_we[i] = (state_q == ST_EXEC) &&
                       (((op_q == OP_WRITE) && addr_q == ADDR_W'(i)) ||
                        ((op_q == OP_WRITE_TAGGED) && tags_q[i]));

    ap_cam_row #(
      .WORD_SIZE (WORD_SIZE)
    ) u_row (
      .clk_i   (CLK100MHZ),
      .rst_n_i (rst),
      .we_i    (row_we[i]),
      .wdata_i (dina_q),
      .wmask_i (row_wmask),
      .key_i   (key_q),
      .cmask_i (mask_q),
      .data_o  (row_data[i]),
      .match_o (row_match[i])
    );
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      tags_q  <= '0;
      doutb_q <= '0;
    end else if (state_q == ST_EXEC) begin
      if (op_q == OP_COMPARE) tags_q <= row_match;
      if (op_q == OP_READ)    doutb_q <= addr_ok ? row_data[addr_q] : '0;
    end
  end

  always_comb begin
    prio_addr = '0;
    for (int i = CELL_QUANT - 1; i >= 0; i--) begin
      if (tags_q[i]) prio_addr = ADDR_W'(i);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      match_any_q  <= 1'b0;
      match_addr_q <= '0;
    end else begin
      resp_valid_q <= (state_q == ST_RESP);
      if (state_q == ST_RESP) begin
        match_any_q  <= |tags_q;
        match_addr_q <= prio_addr;
      end
    end
  end

`ifdef AP_CAM_MATCH_COUNT_EN
  logic [ADDR_W:0] popcnt;
  logic [ADDR_W:0] match_count_q;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < CELL_QUANT; i++) begin
      popcnt = popcnt + (ADDR_W + 1)'(tags_q[i]);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst)                      match_count_q <= '0;
    else if (state_q == ST_RESP)   match_count_q <= popcnt;
  end

  assign match_count = match_count_q;
`endif

  assign cmd_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign doutb      = doutb_q;
  assign tags       = tags_q;
  assign match_any  = match_any_q;
  assign match_addr = match_addr_q;

endmodule : ap_cam_array
`default_nettype wire
